// File: rtl/mem_stage_vl.sv
// MEM pipeline stage with variable-latency data-SRAM responses, load alignment/extension,
// WB-stall buffering and post-flush response discard. Optional forwarding port: MEM_STAGE_FWD_EN.
module mem_stage_vl #(
   parameter int unsigned XLEN      = 32,
   parameter int unsigned RADDR_W   = 5,
   parameter int unsigned MAX_OUTST = 2
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      flush,
   input  logic                      es2ms_valid,
   output logic                      ms_allowin,
   input  logic [31:0]               es_pc,
   input  logic                      es_rf_we,
   input  logic [RADDR_W-1:0]        es_rf_waddr,
   input  logic [XLEN-1:0]           es_alu_result,
   input  logic                      es_mem_req,
   input  logic                      es_res_from_mem,
   input  logic [2:0]                es_ld_op,
   input  logic                      ws_allowin,
   output logic                      ms2ws_valid,
   output logic [31:0]               ms_pc,
`ifdef MEM_STAGE_FWD_EN
   output logic [RADDR_W+XLEN+1:0]   ms_fwd_zip,
`endif
   output logic [RADDR_W+XLEN:0]     ms_rf_zip,
   input  logic                      data_sram_data_ok,
   input  logic [XLEN-1:0]           data_sram_rdata
);

   localparam int unsigned CntW = $clog2(MAX_OUTST + 1);
   localparam int unsigned OffW = $clog2(XLEN / 8);
   localparam int unsigned ShB  = XLEN - 8;
   localparam int unsigned ShH  = XLEN - 16;
   localparam int unsigned ShW  = XLEN - 32;

   logic                 ms_valid;
   logic                 ms_rf_we;
   logic [RADDR_W-1:0]   ms_rf_waddr;
   logic [XLEN-1:0]      ms_alu_result;
   logic                 ms_mem_req;
   logic                 ms_res_from_mem;
   logic [2:0]           ms_ld_op;
   logic                 buf_valid;
   logic [XLEN-1:0]      rdata_buf;
   logic [CntW-1:0]      discard_cnt;

   logic                 ms_ready_go;
   logic                 data_ok_live;
   logic                 cnt_inc;
   logic                 cnt_dec;
   logic                 buf_load;
   logic                 buf_clr;
   logic [XLEN-1:0]      ld_src;
   logic [OffW-1:0]      byte_off;
   logic [XLEN-1:0]      lane_b;
   logic [XLEN-1:0]      lane_h;
   logic [XLEN-1:0]      lane_w;
   logic [XLEN-1:0]      ld_ext;
   logic [XLEN-1:0]      wdata;

   // A response only belongs to the current instruction once all stale ones are drained.
   assign data_ok_live = data_sram_data_ok & (discard_cnt == '0);
   assign ms_ready_go  = ~ms_mem_req | buf_valid | data_ok_live;
   assign ms_allowin   = ~ms_valid | (ms_ready_go & ws_allowin);
   assign ms2ws_valid  = ms_valid & ms_ready_go & ~flush;

   assign cnt_inc  = flush & ms_valid & ms_mem_req & ~buf_valid & ~data_ok_live;
   assign cnt_dec  = data_sram_data_ok & (discard_cnt != '0);
   assign buf_load = data_ok_live & ms_valid & ms_mem_req & ~buf_valid & ~ws_allowin & ~flush;
   assign buf_clr  = (ms2ws_valid & ws_allowin) | flush;

   always_ff @(posedge clk) begin
      if (reset) begin
         ms_valid        <= 1'b0;
         ms_pc           <= '0;
         ms_rf_we        <= 1'b0;
         ms_rf_waddr     <= '0;
         ms_alu_result   <= '0;
         ms_mem_req      <= 1'b0;
         ms_res_from_mem <= 1'b0;
         ms_ld_op        <= '0;
         buf_valid       <= 1'b0;
         rdata_buf       <= '0;
         discard_cnt     <= '0;
      end else begin
         if (flush) begin
            ms_valid <= 1'b0;
         end else if (ms_allowin) begin
            ms_valid <= es2ms_valid;
         end

         if (es2ms_valid & ms_allowin) begin
            ms_pc           <= es_pc;
            ms_rf_we        <= es_rf_we;
            ms_rf_waddr     <= es_rf_waddr;
            ms_alu_result   <= es_alu_result;
            ms_mem_req      <= es_mem_req;
            ms_res_from_mem <= es_res_from_mem;
            ms_ld_op        <= es_ld_op;
         end

         if (buf_clr) begin
            buf_valid <= 1'b0;
         end else if (buf_load) begin
            buf_valid <= 1'b1;
            rdata_buf <= data_sram_rdata;
         end

         if (cnt_inc && !cnt_dec) begin
            if (discard_cnt != CntW'(MAX_OUTST)) begin
               discard_cnt <= discard_cnt + CntW'(1);
            end
         end else if (cnt_dec && !cnt_inc) begin
            discard_cnt <= discard_cnt - CntW'(1);
         end
      end
   end

   // More flushed requests in flight than the memory side can have outstanding.
   discard_overflow: assert property (@(posedge clk) disable iff (reset)
      !(cnt_inc && !cnt_dec && (discard_cnt == CntW'(MAX_OUTST))));

   assign ld_src   = buf_valid ? rdata_buf : data_sram_rdata;
   assign byte_off = ms_alu_result[OffW-1:0];
   assign lane_b   = ld_src >> {byte_off, 3'b000};
   assign lane_h   = ld_src >> {byte_off[OffW-1:1], 4'b0000};
   assign lane_w   = ld_src >> {ms_alu_result[2], 5'b00000};

   // Sign extension by left-justify then arithmetic shift keeps this width-generic.
   always_comb begin
      ld_ext = ld_src;
      case (ms_ld_op)
         3'd1: ld_ext = $signed(lane_h << ShH) >>> ShH;
         3'd2: ld_ext = XLEN'(lane_h[15:0]);
         3'd3: ld_ext = $signed(lane_b << ShB) >>> ShB;
         3'd4: ld_ext = XLEN'(lane_b[7:0]);
         3'd5: if (XLEN == 64) ld_ext = $signed(lane_w << ShW) >>> ShW;
         3'd6: if (XLEN == 64) ld_ext = XLEN'(lane_w[31:0]);
         default: ld_ext = ld_src;
      endcase
   end

   assign wdata     = ms_res_from_mem ? ld_ext : ms_alu_result;
   assign ms_rf_zip = {ms_valid & ms_rf_we, ms_rf_waddr, wdata};

`ifdef MEM_STAGE_FWD_EN
   logic ms_load_pending;
   assign ms_load_pending = ms_valid & ms_res_from_mem & ~ms_ready_go;
   assign ms_fwd_zip      = {ms_valid & ms_rf_we, ms_load_pending, ms_rf_waddr, wdata};
`endif

endmodule

// File: tb/tb_mem_stage_vl.sv
// Directed self-checking bench for mem_stage_vl (XLEN=32 main instance, XLEN=64 extension instance).
module tb_mem_stage_vl;

   logic        clk = 1'b0;
   logic        reset;
   logic        flush;
   logic        es2ms_valid;
   logic        ms_allowin;
   logic [31:0] es_pc;
   logic        es_rf_we;
   logic [4:0]  es_rf_waddr;
   logic [31:0] es_alu_result;
   logic        es_mem_req;
   logic        es_res_from_mem;
   logic [2:0]  es_ld_op;
   logic        ws_allowin;
   logic        ms2ws_valid;
   logic [31:0] ms_pc;
   logic [37:0] ms_rf_zip;
   logic        data_ok;
   logic [31:0] rdata;

   logic        es2ms_valid64;
   logic        ms_allowin64;
   logic [63:0] alu64;
   logic [2:0]  ld_op64;
   logic        ms2ws_valid64;
   logic [31:0] ms_pc64;
   logic [69:0] ms_rf_zip64;
   logic        data_ok64;
   logic [63:0] rdata64;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   mem_stage_vl #(.XLEN(32), .RADDR_W(5), .MAX_OUTST(2)) u_dut (
      .clk               (clk),
      .reset             (reset),
      .flush             (flush),
      .es2ms_valid       (es2ms_valid),
      .ms_allowin        (ms_allowin),
      .es_pc             (es_pc),
      .es_rf_we          (es_rf_we),
      .es_rf_waddr       (es_rf_waddr),
      .es_alu_result     (es_alu_result),
      .es_mem_req        (es_mem_req),
      .es_res_from_mem   (es_res_from_mem),
      .es_ld_op          (es_ld_op),
      .ws_allowin        (ws_allowin),
      .ms2ws_valid       (ms2ws_valid),
      .ms_pc             (ms_pc),
      .ms_rf_zip         (ms_rf_zip),
      .data_sram_data_ok (data_ok),
      .data_sram_rdata   (rdata)
   );

   mem_stage_vl #(.XLEN(64), .RADDR_W(5), .MAX_OUTST(2)) u_dut64 (
      .clk               (clk),
      .reset             (reset),
      .flush             (1'b0),
      .es2ms_valid       (es2ms_valid64),
      .ms_allowin        (ms_allowin64),
      .es_pc             (32'h0000_0400),
      .es_rf_we          (1'b1),
      .es_rf_waddr       (5'd11),
      .es_alu_result     (alu64),
      .es_mem_req        (1'b1),
      .es_res_from_mem   (1'b1),
      .es_ld_op          (ld_op64),
      .ws_allowin        (1'b1),
      .ms2ws_valid       (ms2ws_valid64),
      .ms_pc             (ms_pc64),
      .ms_rf_zip         (ms_rf_zip64),
      .data_sram_data_ok (data_ok64),
      .data_sram_rdata   (rdata64)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Present one instruction on the EXE bus for a single cycle.
   task automatic issue(input logic [31:0] pc, input logic we, input logic [4:0] wa,
                        input logic [31:0] addr, input logic req, input logic rfm,
                        input logic [2:0] op);
      es2ms_valid     = 1'b1;
      es_pc           = pc;
      es_rf_we        = we;
      es_rf_waddr     = wa;
      es_alu_result   = addr;
      es_mem_req      = req;
      es_res_from_mem = rfm;
      es_ld_op        = op;
      tick();
      es2ms_valid     = 1'b0;
      es_pc           = 32'hDEAD_0000;
      es_alu_result   = 32'h5555_5555;
      es_ld_op        = 3'd7;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      #1;
      checks++;
      if (ms2ws_valid !== 1'b0) begin
         failures++; $display("FAIL reset_valid got=%b exp=0", ms2ws_valid);
      end
      checks++;
      if (ms_rf_zip !== 38'h0) begin
         failures++; $display("FAIL reset_zip got=%h exp=0", ms_rf_zip);
      end
      checks++;
      if (ms_pc !== 32'h0) begin
         failures++; $display("FAIL reset_pc got=%h exp=0", ms_pc);
      end
      checks++;
      if (ms_allowin !== 1'b1) begin
         failures++; $display("FAIL reset_allowin got=%b exp=1", ms_allowin);
      end
   endtask

   task automatic test_lb_first_cycle;
      ws_allowin = 1'b1;
      issue(32'h0000_0100, 1'b1, 5'd3, 32'h0000_1003, 1'b1, 1'b1, 3'd3);
      data_ok = 1'b1;
      rdata   = 32'h80FF_1234;
      #1;
      checks++;
      if (ms2ws_valid !== 1'b1) begin
         failures++; $display("FAIL lb_valid got=%b exp=1", ms2ws_valid);
      end
      checks++;
      if (ms_rf_zip !== {1'b1, 5'd3, 32'hFFFF_FF80}) begin
         failures++; $display("FAIL lb_zip got=%h exp=%h", ms_rf_zip, {1'b1, 5'd3, 32'hFFFF_FF80});
      end
      checks++;
      if (ms_pc !== 32'h0000_0100) begin
         failures++; $display("FAIL lb_pc got=%h exp=00000100", ms_pc);
      end
      checks++;
      if (ms_allowin !== 1'b1) begin
         failures++; $display("FAIL lb_allowin got=%b exp=1", ms_allowin);
      end
      tick();
      data_ok = 1'b0;
      #1;
      checks++;
      if (ms2ws_valid !== 1'b0) begin
         failures++; $display("FAIL lb_retired got=%b exp=0", ms2ws_valid);
      end
   endtask

   task automatic test_lhu_stall;
      issue(32'h0000_0104, 1'b1, 5'd5, 32'h0000_2002, 1'b1, 1'b1, 3'd2);
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++;
         if (ms_allowin !== 1'b0) begin
            failures++; $display("FAIL lhu_stall_allowin[%0d] got=%b exp=0", i, ms_allowin);
         end
         checks++;
         if (ms2ws_valid !== 1'b0) begin
            failures++; $display("FAIL lhu_stall_valid[%0d] got=%b exp=0", i, ms2ws_valid);
         end
         tick();
      end
      data_ok = 1'b1;
      rdata   = 32'hBEEF_0001;
      #1;
      checks++;
      if (ms2ws_valid !== 1'b1) begin
         failures++; $display("FAIL lhu_valid got=%b exp=1", ms2ws_valid);
      end
      checks++;
      if (ms_rf_zip !== {1'b1, 5'd5, 32'h0000_BEEF}) begin
         failures++; $display("FAIL lhu_zip got=%h exp=%h", ms_rf_zip, {1'b1, 5'd5, 32'h0000_BEEF});
      end
      tick();
      data_ok = 1'b0;
   endtask

   task automatic test_buffer;
      issue(32'h0000_0108, 1'b1, 5'd7, 32'h0000_3000, 1'b1, 1'b1, 3'd0);
      ws_allowin = 1'b0;
      data_ok    = 1'b1;
      rdata      = 32'h1234_5678;
      #1;
      checks++;
      if (ms_allowin !== 1'b0) begin
         failures++; $display("FAIL buf_allowin got=%b exp=0", ms_allowin);
      end
      tick();
      data_ok = 1'b0;
      rdata   = 32'hCAFE_F00D;
      for (int i = 0; i < 2; i++) begin
         #1;
         checks++;
         if (u_dut.buf_valid !== 1'b1) begin
            failures++; $display("FAIL buf_held[%0d] got=%b exp=1", i, u_dut.buf_valid);
         end
         checks++;
         if (ms_rf_zip[31:0] !== 32'h1234_5678) begin
            failures++; $display("FAIL buf_data[%0d] got=%h exp=12345678", i, ms_rf_zip[31:0]);
         end
         tick();
         rdata = 32'h0BAD_0BAD;
      end
      ws_allowin = 1'b1;
      #1;
      checks++;
      if (ms2ws_valid !== 1'b1 || ms_rf_zip !== {1'b1, 5'd7, 32'h1234_5678}) begin
         failures++; $display("FAIL buf_release got=%b/%h exp=1/%h", ms2ws_valid, ms_rf_zip,
                              {1'b1, 5'd7, 32'h1234_5678});
      end
      tick();
      checks++;
      if (u_dut.buf_valid !== 1'b0 || ms2ws_valid !== 1'b0) begin
         failures++; $display("FAIL buf_clear got=%b/%b exp=0/0", u_dut.buf_valid, ms2ws_valid);
      end
   endtask

   task automatic test_flush_discard;
      issue(32'h0000_010C, 1'b1, 5'd8, 32'h0000_4000, 1'b1, 1'b1, 3'd0);
      flush = 1'b1;
      #1;
      checks++;
      if (ms2ws_valid !== 1'b0) begin
         failures++; $display("FAIL flush_valid got=%b exp=0", ms2ws_valid);
      end
      tick();
      flush = 1'b0;
      checks++;
      if (u_dut.discard_cnt !== 2'd1) begin
         failures++; $display("FAIL flush_cnt got=%0d exp=1", u_dut.discard_cnt);
      end
      issue(32'h0000_0110, 1'b1, 5'd9, 32'h0000_5000, 1'b1, 1'b1, 3'd3);
      data_ok = 1'b1;
      rdata   = 32'hAAAA_AAAA;
      #1;
      checks++;
      if (ms2ws_valid !== 1'b0 || ms_allowin !== 1'b0) begin
         failures++; $display("FAIL discard_drop got=%b/%b exp=0/0", ms2ws_valid, ms_allowin);
      end
      tick();
      checks++;
      if (u_dut.discard_cnt !== 2'd0) begin
         failures++; $display("FAIL discard_cnt got=%0d exp=0", u_dut.discard_cnt);
      end
      rdata = 32'h0000_007F;
      #1;
      checks++;
      if (ms2ws_valid !== 1'b1 || ms_rf_zip !== {1'b1, 5'd9, 32'h0000_007F}) begin
         failures++; $display("FAIL discard_next got=%b/%h exp=1/%h", ms2ws_valid, ms_rf_zip,
                              {1'b1, 5'd9, 32'h0000_007F});
      end
      tick();
      data_ok = 1'b0;
   endtask

   task automatic test_store;
      issue(32'h0000_0114, 1'b0, 5'd0, 32'h0000_6000, 1'b1, 1'b0, 3'd0);
      #1;
      checks++;
      if (ms_allowin !== 1'b0 || ms2ws_valid !== 1'b0) begin
         failures++; $display("FAIL store_wait got=%b/%b exp=0/0", ms_allowin, ms2ws_valid);
      end
      tick();
      data_ok = 1'b1;
      rdata   = 32'hFFFF_FFFF;
      #1;
      checks++;
      if (ms2ws_valid !== 1'b1 || ms_rf_zip !== {1'b0, 5'd0, 32'h0000_6000}) begin
         failures++; $display("FAIL store_done got=%b/%h exp=1/%h", ms2ws_valid, ms_rf_zip,
                              {1'b0, 5'd0, 32'h0000_6000});
      end
      tick();
      data_ok = 1'b0;
   endtask

   task automatic test_xlen64;
      logic [63:0] exp_w [2];
      exp_w[0] = 64'hFFFF_FFFF_8000_0001;
      exp_w[1] = 64'h0000_0000_8000_0001;
      for (int i = 0; i < 2; i++) begin
         es2ms_valid64 = 1'b1;
         alu64         = 64'h0000_0000_0000_7004;
         ld_op64       = (i == 0) ? 3'd5 : 3'd6;
         tick();
         es2ms_valid64 = 1'b0;
         data_ok64     = 1'b1;
         rdata64       = 64'h8000_0001_0000_0002;
         #1;
         checks++;
         if (ms2ws_valid64 !== 1'b1 || ms_rf_zip64[63:0] !== exp_w[i]) begin
            failures++; $display("FAIL x64_word[%0d] got=%b/%h exp=1/%h", i, ms2ws_valid64,
                                 ms_rf_zip64[63:0], exp_w[i]);
         end
         tick();
         data_ok64 = 1'b0;
      end
   endtask

   task automatic test_reset_mid;
      issue(32'h0000_0118, 1'b1, 5'd10, 32'h0000_7000, 1'b1, 1'b1, 3'd0);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      issue(32'h0000_011C, 1'b1, 5'd12, 32'h0000_7004, 1'b1, 1'b1, 3'd0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #1;
      checks++;
      if (ms2ws_valid !== 1'b0) begin
         failures++; $display("FAIL rstmid_valid got=%b exp=0", ms2ws_valid);
      end
      checks++;
      if (ms_rf_zip !== 38'h0) begin
         failures++; $display("FAIL rstmid_zip got=%h exp=0", ms_rf_zip);
      end
      checks++;
      if (u_dut.discard_cnt !== 2'd0) begin
         failures++; $display("FAIL rstmid_cnt got=%0d exp=0", u_dut.discard_cnt);
      end
   endtask

   initial begin
      reset           = 1'b1;
      flush           = 1'b0;
      es2ms_valid     = 1'b0;
      es_pc           = '0;
      es_rf_we        = 1'b0;
      es_rf_waddr     = '0;
      es_alu_result   = '0;
      es_mem_req      = 1'b0;
      es_res_from_mem = 1'b0;
      es_ld_op        = '0;
      ws_allowin      = 1'b1;
      data_ok         = 1'b0;
      rdata           = '0;
      es2ms_valid64   = 1'b0;
      alu64           = '0;
      ld_op64         = '0;
      data_ok64       = 1'b0;
      rdata64         = '0;

      test_reset();
      test_lb_first_cycle();
      test_lhu_stall();
      test_buffer();
      test_flush_discard();
      test_store();
      test_xlen64();
      test_reset_mid();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_stage_vl.md
Name: mem_stage_vl

Overview:
- Parametrised next-generation MEM pipeline stage. Sits between EXE and WB.
- Accepts the EXE→MEM bus and waits for a variable-latency data-SRAM response (data_ok) instead of assuming fixed one-cycle read data.
- Aligns and extends load data for XLEN 32 or 64 and buffers returned data while WB stalls.
- Drops responses belonging to flushed instructions.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64.
- RADDR_W, 5, register-file write-address width.
- MAX_OUTST, 2, maximum in-flight data requests to discard after a flush; discard counter width is clog2(MAX_OUTST+1).

Ports:
- clk  in  1  clock; all state changes on posedge.
- reset  in  1  synchronous, active-high.
- flush  in  1  pipeline flush (exception/ertn); kills the MEM instruction.
- es2ms_valid  in  1  EXE holds a valid instruction.
- ms_allowin  out  1  MEM can accept this cycle.
- es_pc  in  32  EXE PC.
- es_rf_we  in  1  register write enable.
- es_rf_waddr  in  RADDR_W  destination register.
- es_alu_result  in  XLEN  ALU result / memory address.
- es_mem_req  in  1  a data request was issued in EXE (load or store).
- es_res_from_mem  in  1  writeback value comes from memory.
- es_ld_op  in  3  0=full, 1=H, 2=HU, 3=B, 4=BU, 5=W signed, 6=WU (5/6 only when XLEN=64), 7 reserved.
- ws_allowin  in  1  WB can accept.
- ms2ws_valid  out  1  MEM result valid to WB.
- ms_pc  out  32  MEM PC.
- ms_rf_zip  out  1+RADDR_W+XLEN  {we&valid, waddr, wdata}.
- data_sram_data_ok  in  1  read/write response this cycle.
- data_sram_rdata  in  XLEN  response data, valid when data_ok.

Behaviour:
- Reset: ms_valid=0, ms_pc=0, all latched fields=0, buf_valid=0, discard_cnt=0. Consequently ms2ws_valid=0 and ms_rf_zip=0.
- Handshake:
  - ms_ready_go = ~ms_mem_req | buf_valid | (data_ok & discard_cnt==0).
  - ms_allowin = ~ms_valid | (ms_ready_go & ws_allowin).
  - ms2ws_valid = ms_valid & ms_ready_go & ~flush.
- Valid register:
  - flush: ms_valid←0.
  - otherwise on ms_allowin: ms_valid←es2ms_valid. Fields latch when es2ms_valid & ms_allowin.
- Response routing:
  - data_ok with discard_cnt>0: decrement discard_cnt; response consumed, never used.
  - data_ok with discard_cnt==0, ms_valid & ms_mem_req & ~buf_valid & ~ws_allowin: rdata→rdata_buf, buf_valid←1.
  - buf_valid clears when the instruction moves to WB (ms2ws_valid & ws_allowin) or on flush.
- Flush accounting: flush while ms_valid & ms_mem_req & ~buf_valid & ~data_ok → discard_cnt+1.
  - Flush concurrent with data_ok for the same instruction: no increment.
  - Saturate at MAX_OUTST; reaching saturation is a design error (assertion).
- Extension: source = buf_valid ? rdata_buf : data_sram_rdata.
  - Byte lane from addr[clog2(XLEN/8)-1:0]; halfword lane from addr[..:1]; word lane from addr[2] (XLEN=64).
  - Signed ops sign-extend; U ops zero-extend; full passes through unchanged.
- wdata = ms_res_from_mem ? extended load : ms_alu_result.
- Stores: es_mem_req=1, es_res_from_mem=0. The stage waits for data_ok; rdata is ignored.
- Simultaneous data_ok and ws_allowin: data passes straight through with no buffering. Zero added latency when data_ok arrives in the first MEM cycle.
- Reset mid-request: all state cleared, discard_cnt=0. The memory side is reset by the same signal.

Optional Feature:
- Macro: MEM_STAGE_FWD_EN.
- Defined: adds output ms_fwd_zip, 2+RADDR_W+XLEN wide = {ms_valid&ms_rf_we, ms_load_pending, waddr, wdata}.
  - ms_load_pending = ms_valid & ms_res_from_mem & ~ms_ready_go.
  - ID uses it to bypass, or to stall while pending is set.
- Undefined: port absent; no extra logic.

Test Plan:
- LB, XLEN=32, addr 0x1003, data_ok in first MEM cycle, rdata 0x80FF_1234 → ms2ws_valid same cycle; wdata 0xFFFF_FF80.
- LHU addr 0x2002, data_ok after 3 stall cycles, rdata 0xBEEF_0001 → ms_allowin=0 for 3 cycles; wdata 0x0000_BEEF.
- LW, data_ok while ws_allowin=0 for 2 cycles, rdata 0x1234_5678 → buf_valid=1; later ws_allowin=1 → wdata 0x1234_5678, buf_valid→0; bus changes ignored.
- flush with LW outstanding, then new LB enters; first data_ok (0xAAAA_AAAA) → dropped, discard_cnt 1→0; second data_ok 0x0000_007F → wdata 0x7F.
- XLEN=64, op W at addr 0x...4, rdata 0x8000_0001_0000_0002 → wdata 0xFFFF_FFFF_8000_0001; op WU → 0x0000_0000_8000_0001.
- reset asserted while a load waits → next cycle ms2ws_valid=0, ms_rf_zip=0, discard_cnt=0.
